// File: rtl/serial_pkg.sv
// Shared types for the serial link receive path: word layout and capture FSM states.
package serial_pkg;

  localparam int PAD_W = 4;
  localparam int PKT_W = 42;

  typedef struct packed {
    logic [PAD_W-1:0] padding;
    logic [PKT_W-1:0] packet;
  } serial_word_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    WAIT_LOW = 2'd2
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separate occupancy counter and a combinational head read.
module sync_fifo
  import serial_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = serial_word_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       wr_data,
  input  logic                   pop,
  output T                       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T                mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            do_push;
  logic            do_pop;

  // Flags come straight from the registered count, so a pop never frees a slot for a push in the same cycle.
  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/serial_rx_buffer.sv
// Captures receiver words into a FIFO and pulses rx_flush once per captured word.
// Optional capture counter and stall flag are built when SERIAL_RX_STATS_EN is defined.
module serial_rx_buffer
  import serial_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_valid,
  input  logic [PAD_W-1:0]       rx_padding,
  input  logic [PKT_W-1:0]       rx_packet,
  output logic                   rx_flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PAD_W-1:0]       out_padding,
  output logic [PKT_W-1:0]       out_packet,
  output logic [$clog2(DEPTH):0] count
`ifdef SERIAL_RX_STATS_EN
  ,
  output logic [15:0]            rx_pkt_count,
  output logic                   rx_stall
`endif
);

  rx_state_t    state_reg;
  logic         flush_reg;
  logic         push;
  logic         fifo_full;
  logic         fifo_empty;
  serial_word_t wr_word;
  serial_word_t head_word;

  assign wr_word.padding = rx_padding;
  assign wr_word.packet  = rx_packet;
  assign push            = (state_reg == IDLE) && rx_valid && !fifo_full;

  sync_fifo #(
    .DEPTH (DEPTH),
    .T     (serial_word_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (wr_word),
    .pop     (out_ready),
    .rd_data (head_word),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  // WAIT_LOW blocks re-capture until the receiver has visibly dropped its word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      flush_reg <= 1'b0;
    end else begin
      flush_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (push) begin
            state_reg <= FLUSH;
            flush_reg <= 1'b1;
          end
        end
        FLUSH:    state_reg <= WAIT_LOW;
        WAIT_LOW: if (!rx_valid) state_reg <= IDLE;
        default:  state_reg <= IDLE;
      endcase
    end
  end

  assign rx_flush    = flush_reg;
  assign out_valid   = !fifo_empty;
  assign out_padding = head_word.padding;
  assign out_packet  = head_word.packet;

`ifdef SERIAL_RX_STATS_EN
  logic [15:0] pkt_count_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pkt_count_reg <= '0;
    end else if (push) begin
      pkt_count_reg <= pkt_count_reg + 16'd1;
    end
  end

  assign rx_pkt_count = pkt_count_reg;
  assign rx_stall     = (state_reg == IDLE) && rx_valid && fifo_full;
`endif

endmodule

// File: tb/tb_serial_rx_buffer.sv
// Scoreboard bench for serial_rx_buffer: stimulus queues expected words, a negedge monitor checks every pop.
module tb_serial_rx_buffer;
  import serial_pkg::*;

  localparam int DEPTH = 4;

  logic                   clk;
  logic                   rst;
  logic                   rx_valid;
  logic [PAD_W-1:0]       rx_padding;
  logic [PKT_W-1:0]       rx_packet;
  logic                   rx_flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [PAD_W-1:0]       out_padding;
  logic [PKT_W-1:0]       out_packet;
  logic [$clog2(DEPTH):0] count;
`ifdef SERIAL_RX_STATS_EN
  logic [15:0]            rx_pkt_count;
  logic                   rx_stall;
`endif

  int checks   = 0;
  int failures = 0;
  int flush_cnt = 0;
  logic prev_flush = 1'b0;
  serial_word_t exp_q[$];

  serial_rx_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_padding  (rx_padding),
    .rx_packet   (rx_packet),
    .rx_flush    (rx_flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_padding (out_padding),
    .out_packet  (out_packet),
    .count       (count)
`ifdef SERIAL_RX_STATS_EN
    ,
    .rx_pkt_count(rx_pkt_count),
    .rx_stall    (rx_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  // Monitor: one line per popped word, compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", 64'(out_packet), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        serial_word_t e;
        e = exp_q.pop_front();
        check("head_padding", 64'(out_padding), 64'(e.padding));
        check("head_packet", 64'(out_packet), 64'(e.packet));
      end
    end
    if (rx_flush) begin
      flush_cnt++;
      check("flush_single_cycle", 64'(prev_flush), 64'd0);
    end
    prev_flush = rx_flush;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Receiver model: present a word, wait for its flush, optionally hold, then drop.
  task automatic send_word(input logic [PAD_W-1:0] p, input logic [PKT_W-1:0] k, input int hold);
    int n;
    rx_padding = p;
    rx_packet  = k;
    rx_valid   = 1'b1;
    exp_q.push_back('{padding: p, packet: k});
    n = 0;
    tick();
    while (!rx_flush && n < 50) begin
      tick();
      n++;
    end
    check("flush_seen", 64'(rx_flush), 64'd1);
    tick();
    repeat (hold) tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic pulse_pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (count != 0 && n < 100) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    check("drain_count", 64'(count), 64'd0);
    check("drain_valid", 64'(out_valid), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int f0;
    rst        = 1'b0;
    rx_valid   = 1'b0;
    rx_padding = '0;
    rx_packet  = '0;
    out_ready  = 1'b0;
    repeat (3) tick();
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_flush", 64'(rx_flush), 64'd0);
    check("reset_count", 64'(count), 64'd0);
    rst = 1'b1;
    tick();

    // Fill and stall: four words fit, the fifth waits for a pop.
    f0 = flush_cnt;
    for (int i = 1; i <= 4; i++) send_word(4'(i), 42'(i), 0);
    check("fill_count", 64'(count), 64'd4);
    check("fill_flushes", 64'(flush_cnt - f0), 64'd4);
    rx_padding = 4'd5;
    rx_packet  = 42'h5;
    rx_valid   = 1'b1;
    exp_q.push_back('{padding: 4'd5, packet: 42'h5});
    repeat (3) tick();
`ifdef SERIAL_RX_STATS_EN
    check("stats_stall_high", 64'(rx_stall), 64'd1);
`endif
    check("stall_no_flush", 64'(flush_cnt - f0), 64'd4);
    check("stall_count", 64'(count), 64'd4);
    pulse_pop();
    check("pop_count", 64'(count), 64'd3);
    check("pop_no_same_cycle_flush", 64'(rx_flush), 64'd0);
    tick();
    check("late_capture_flush", 64'(rx_flush), 64'd1);
    check("late_capture_count", 64'(count), 64'd4);
`ifdef SERIAL_RX_STATS_EN
    check("stats_pkt_count", 64'(rx_pkt_count), 64'd5);
`endif
    tick();
    rx_valid = 1'b0;
    tick();
    drain();

    // Single word, no backpressure, with first-cycle latency checks.
    rx_padding = 4'b1011;
    rx_packet  = 42'h2AC19440329;
    rx_valid   = 1'b1;
    exp_q.push_back('{padding: 4'b1011, packet: 42'h2AC19440329});
    tick();
    check("single_flush", 64'(rx_flush), 64'd1);
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_count", 64'(count), 64'd1);
    check("single_padding", 64'(out_padding), 64'hB);
    check("single_packet", 64'(out_packet), 64'h2AC19440329);
    tick();
    check("single_flush_low", 64'(rx_flush), 64'd0);
    rx_valid = 1'b0;
    tick();
    drain();

    // Simultaneous push and pop at count=2, enough times to wrap both pointers.
    send_word(4'hA, 42'h3FF_0000_0001, 0);
    send_word(4'hB, 42'h3FF_0000_0002, 0);
    for (int i = 0; i < 10; i++) begin
      rx_padding = 4'(i);
      rx_packet  = 42'h100 + 42'(i);
      rx_valid   = 1'b1;
      out_ready  = 1'b1;
      exp_q.push_back('{padding: 4'(i), packet: 42'h100 + 42'(i)});
      tick();
      out_ready = 1'b0;
      check("pushpop_count", 64'(count), 64'd2);
      tick();
      rx_valid = 1'b0;
      tick();
    end
    drain();

    // Slow receiver keeps rx_valid high after the flush.
    f0 = flush_cnt;
    send_word(4'h7, 42'h155_5555_5555, 3);
    repeat (2) tick();
    check("held_count", 64'(count), 64'd1);
    check("held_flushes", 64'(flush_cnt - f0), 64'd1);
    drain();

    // Reset while in FLUSH with three entries; the held word is recaptured once.
    send_word(4'h1, 42'h0AA, 0);
    send_word(4'h2, 42'h0BB, 0);
    rx_padding = 4'h3;
    rx_packet  = 42'h0CC;
    rx_valid   = 1'b1;
    tick();
    check("pre_reset_count", 64'(count), 64'd3);
    check("pre_reset_flush", 64'(rx_flush), 64'd1);
    rst = 1'b0;
    tick();
    check("mid_reset_count", 64'(count), 64'd0);
    check("mid_reset_valid", 64'(out_valid), 64'd0);
    check("mid_reset_flush", 64'(rx_flush), 64'd0);
    exp_q.delete();
    exp_q.push_back('{padding: 4'h3, packet: 42'h0CC});
    rst = 1'b1;
    tick();
    check("recapture_flush", 64'(rx_flush), 64'd1);
    check("recapture_count", 64'(count), 64'd1);
    tick();
    rx_valid = 1'b0;
    repeat (3) tick();
    check("recapture_once", 64'(count), 64'd1);
    drain();

`ifdef SERIAL_RX_STATS_EN
    dut.pkt_count_reg = 16'hFFFF;
    send_word(4'h9, 42'h999, 0);
    check("stats_wrap", 64'(rx_pkt_count), 64'd0);
    drain();
`endif

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
